// File: rtl/conv_enc.sv
// Rate-1/2, K=3 convolutional encoder; serializes one message word per frame MSB first.
// Define CONV_ENC_TAIL_EN to append two zero tail bits that return the trellis to state 00.
module conv_enc #(
    parameter int         DATA_BITS = 6,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 sym_valid,
    output logic [1:0]           sym,
    input  logic                 sym_ready,
    output logic                 sym_last,
    output logic                 busy,
    output logic [7:0]           frame_cnt
);

    localparam int             CW        = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS);
    localparam logic [CW-1:0]  LAST_DATA = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t                 state, state_n;
    logic [DATA_BITS-1:0]   word_buf, word_buf_n;
    logic [1:0]             enc_s, enc_s_n;
    logic [CW-1:0]          bit_cnt, bit_cnt_n;
    logic [1:0]             sym_n;
    logic                   sym_valid_n, sym_last_n;
    logic                   step, u;

    function automatic logic [1:0] encode(input logic bit_u, input logic [1:0] st);
        encode = {^(G0 & {bit_u, st}), ^(G1 & {bit_u, st})};
    endfunction

    // A step produces one coded symbol whenever a frame is active and the output slot is free.
    always_comb begin
        state_n     = state;
        word_buf_n  = word_buf;
        enc_s_n     = enc_s;
        bit_cnt_n   = bit_cnt;
        sym_n       = sym;
        sym_valid_n = sym_valid;
        sym_last_n  = sym_last;
        u           = 1'b0;
        step        = (state != IDLE) && (!sym_valid || sym_ready);

        if (sym_valid && sym_ready) begin
            sym_valid_n = 1'b0;
            sym_last_n  = 1'b0;
        end

        case (state)
            IDLE: begin
                if (in_valid) begin
                    word_buf_n = in_data;
                    enc_s_n    = 2'b00;
                    bit_cnt_n  = '0;
                    state_n    = DATA;
                end
            end
            DATA: begin
                if (step) begin
                    u           = word_buf[DATA_BITS-1];
                    sym_n       = encode(u, enc_s);
                    sym_valid_n = 1'b1;
                    sym_last_n  = 1'b0;
                    enc_s_n     = {u, enc_s[1]};
                    word_buf_n  = word_buf << 1;
                    bit_cnt_n   = bit_cnt + CW'(1);
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_n = '0;
`ifdef CONV_ENC_TAIL_EN
                        state_n   = TAIL;
`else
                        state_n    = IDLE;
                        sym_last_n = 1'b1;
`endif
                    end
                end
            end
`ifdef CONV_ENC_TAIL_EN
            TAIL: begin
                if (step) begin
                    sym_n       = encode(1'b0, enc_s);
                    sym_valid_n = 1'b1;
                    sym_last_n  = 1'b0;
                    enc_s_n     = {1'b0, enc_s[1]};
                    bit_cnt_n   = bit_cnt + CW'(1);
                    if (bit_cnt == CW'(1)) begin
                        state_n    = IDLE;
                        sym_last_n = 1'b1;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            word_buf  <= '0;
            enc_s     <= 2'b00;
            bit_cnt   <= '0;
            sym       <= 2'b00;
            sym_valid <= 1'b0;
            sym_last  <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            word_buf  <= word_buf_n;
            enc_s     <= enc_s_n;
            bit_cnt   <= bit_cnt_n;
            sym       <= sym_n;
            sym_valid <= sym_valid_n;
            sym_last  <= sym_last_n;
            if (sym_valid && sym_ready && sym_last)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE) || sym_valid;

endmodule

// File: tb/tb_conv_enc.sv
// Self-checking bench for conv_enc: directed test-plan frames plus randomized frames and
// backpressure, checked cycle by cycle against a frame-level reference model.
module tb_conv_enc;

    localparam int         DATA_BITS = 6;
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;
`ifdef CONV_ENC_TAIL_EN
    localparam int TAIL_LEN = 2;
`else
    localparam int TAIL_LEN = 0;
`endif
    localparam int FL = DATA_BITS + TAIL_LEN;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_ready;
    logic                 sym_valid;
    logic [1:0]           sym;
    logic                 sym_ready;
    logic                 sym_last;
    logic                 busy;
    logic [7:0]           frame_cnt;

    conv_enc #(.DATA_BITS(DATA_BITS), .G0(G0), .G1(G1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready), .sym_last(sym_last),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: symbols still to be generated for the current frame, plus the output slot.
    logic [2:0] genq[$];
    logic       m_valid, m_last;
    logic [1:0] m_sym;
    logic [7:0] m_fc;
    logic [1:0] seen_sym[$];
    logic       seen_last[$];
    int         errors, checks;

    logic [1:0] exp_a [8];
    logic [1:0] exp_b [8];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expands a word into its coded symbol list using the generator parity rule.
    task automatic build_frame(input logic [DATA_BITS-1:0] w);
        int st;
        int ub;
        logic [2:0] reg3;
        logic c0, c1;
        st = 0;
        for (int i = 0; i < FL; i++) begin
            ub   = (i < DATA_BITS) ? int'(w[DATA_BITS-1-i]) : 0;
            reg3 = 3'(ub * 4 + st);
            c0   = ($countones(G0 & reg3) % 2) == 1;
            c1   = ($countones(G1 & reg3) % 2) == 1;
            genq.push_back({c0, c1, (i == FL - 1)});
            st   = ub * 2 + st / 2;
        end
    endtask

    task automatic model_reset();
        genq.delete();
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_sym   = 2'b00;
        m_fc    = 8'd0;
    endtask

    // Called at a falling edge with inputs set: checks outputs, advances the model one clock.
    task automatic cycle();
        logic [2:0] e;
        logic consume, accept;
        checkOutput("in_ready", 32'(in_ready), 32'(genq.size() == 0));
        checkOutput("sym_valid", 32'(sym_valid), 32'(m_valid));
        checkOutput("sym_last", 32'(sym_last), 32'(m_last));
        if (m_valid) checkOutput("sym", 32'(sym), 32'(m_sym));
        checkOutput("busy", 32'(busy), 32'((genq.size() != 0) || m_valid));
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(m_fc));
        consume = m_valid && sym_ready;
        accept  = (genq.size() == 0) && in_valid;
        if (consume) begin
            seen_sym.push_back(sym);
            seen_last.push_back(sym_last);
            if (m_last) m_fc = m_fc + 8'd1;
        end
        if ((genq.size() != 0) && (!m_valid || sym_ready)) begin
            e       = genq.pop_front();
            m_sym   = e[2:1];
            m_last  = e[0];
            m_valid = 1'b1;
        end else if (consume) begin
            m_valid = 1'b0;
            m_last  = 1'b0;
        end
        if (accept) build_frame(in_data);
        @(negedge clk);
    endtask

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        if (mode == 2) return $urandom_range(0, 3) != 0;
        return 1'b1;
    endfunction

    // Offers one word while idle, then drains the frame under the chosen sym_ready pattern.
    task automatic applyStimulus(input logic [DATA_BITS-1:0] w, input int mode);
        in_valid  = 1'b1;
        in_data   = w;
        sym_ready = ready_for(mode, 0);
        cycle();
        in_valid  = 1'b0;
        in_data   = DATA_BITS'($urandom);
        for (int k = 1; k < 400; k++) begin
            if (genq.size() == 0 && !m_valid) break;
            sym_ready = ready_for(mode, k);
            cycle();
        end
        sym_ready = 1'b0;
    endtask

    task automatic check_sequence(input string tag, input logic [1:0] expv [8]);
        checkOutput({tag, "_count"}, 32'(seen_sym.size()), 32'(FL));
        for (int i = 0; i < FL; i++) begin
            if (i < seen_sym.size()) begin
                checkOutput({tag, "_sym"}, 32'(seen_sym[i]), 32'(expv[i]));
                checkOutput({tag, "_last"}, 32'(seen_last[i]), 32'(i == FL - 1));
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_sym"}, 32'(sym), 32'(2'b00));
        checkOutput({tag, "_sym_valid"}, 32'(sym_valid), 32'(0));
        checkOutput({tag, "_sym_last"}, 32'(sym_last), 32'(0));
        checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
        checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(0));
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    endtask

    initial begin
        int acc;
        logic [7:0] fc0;
        logic [DATA_BITS-1:0] wa, wb;
        errors = 0;
        checks = 0;
        exp_a = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
        exp_b = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b11};
        model_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; sym_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Reference frame with free-flowing output.
        seen_sym.delete(); seen_last.delete();
        applyStimulus(6'b101100, 0);
        check_sequence("frame_101100", exp_a);
        checkOutput("frame_cnt_first", 32'(frame_cnt), 32'(1));

        seen_sym.delete(); seen_last.delete();
        applyStimulus(6'b000001, 0);
        check_sequence("frame_000001", exp_b);

        // Same frame under a 1,0,0,1 backpressure pattern.
        seen_sym.delete(); seen_last.delete();
        applyStimulus(6'b101100, 1);
        check_sequence("stall_101100", exp_a);

        // Two words offered back to back; in_data changes while busy and must be ignored.
        seen_sym.delete(); seen_last.delete();
        fc0 = m_fc;
        wa = DATA_BITS'($urandom); wb = DATA_BITS'($urandom);
        acc = 0;
        in_valid = 1'b1; in_data = wa; sym_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (acc == 2 && genq.size() == 0 && !m_valid) break;
            if (acc == 2) in_valid = 1'b0;
            else if (acc == 1 && genq.size() == 0) in_data = wb;
            else if (acc == 1) in_data = DATA_BITS'($urandom);
            if (genq.size() == 0 && in_valid) acc++;
            cycle();
        end
        in_valid = 1'b0;
        checkOutput("b2b_count", 32'(seen_sym.size()), 32'(2 * FL));
        if (seen_last.size() == 2 * FL) begin
            checkOutput("b2b_last_first", 32'(seen_last[FL-1]), 32'(1));
            checkOutput("b2b_last_second", 32'(seen_last[2*FL-1]), 32'(1));
        end
        checkOutput("b2b_frame_cnt", 32'(frame_cnt), 32'(fc0 + 8'd2));

        // Reset in the middle of a frame, then a clean frame.
        seen_sym.delete(); seen_last.delete();
        in_valid = 1'b1; in_data = 6'b101100; sym_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (seen_sym.size() >= 3) break;
            cycle();
        end
        rst = 1'b1;
        #1;
        check_reset_values("midframe_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        seen_sym.delete(); seen_last.delete();
        applyStimulus(6'b101100, 0);
        check_sequence("after_reset", exp_a);

        // Randomized words, gaps and backpressure.
        for (int f = 0; f < 30; f++) begin
            in_valid = 1'b0;
            sym_ready = 1'b1;
            for (int g = $urandom_range(0, 3); g > 0; g--) cycle();
            applyStimulus(DATA_BITS'($urandom), 2);
        end

        // frame_cnt wraps after 256 frames from reset.
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        @(negedge clk);
        for (int f = 0; f < 256; f++) applyStimulus(DATA_BITS'($urandom), 0);
        checkOutput("frame_cnt_wrap", 32'(frame_cnt), 32'(0));

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
